// File: rtl/tb_tcdm_memory_model.sv
// Multi-port TCDM slave memory model: per-port LFSR stall injection, lowest-index
// conflict arbitration, fixed-latency response pipelines and access counters.
module tb_tcdm_memory_model #(
    parameter int          MP          = 2,
    parameter int          DW          = 32,
    parameter int          MEMORY_SIZE = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          LATENCY     = 1,
    parameter int          STALL_TH    = 0,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   stallable_i,
    input  logic                   clear_i,
    input  logic [MP-1:0]          req_i,
    input  logic [MP*32-1:0]       add_i,
    input  logic [MP-1:0]          wen_i,
    input  logic [MP*(DW/8)-1:0]   be_i,
    input  logic [MP*DW-1:0]       data_i,
    output logic [MP-1:0]          gnt_o,
    output logic [MP*DW-1:0]       r_data_o,
    output logic [MP-1:0]          r_valid_o,
    output logic                   err_o,
    output logic [MP*32-1:0]       cnt_rd_o,
    output logic [MP*32-1:0]       cnt_wr_o,
    output logic [MP*32-1:0]       cnt_stall_o
);

    localparam int BW   = DW / 8;
    localparam int OFFS = $clog2(BW);
    localparam int AW   = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

    logic [DW-1:0] mem [MEMORY_SIZE];

    logic [7:0]    lfsr        [MP];
    logic [31:0]   addr        [MP];
    logic [31:0]   word_idx    [MP];
    logic [DW-1:0] rd_word     [MP];
    logic [DW-1:0] merged      [MP];
    logic [DW-1:0] resp_dat_p0 [MP];
    logic [MP-1:0] in_range, stall, active, lost, gnt, oor_gnt;

    logic [MP-1:0] vld_pipe [LATENCY];
    logic [DW-1:0] dat_pipe [LATENCY][MP];

    logic [31:0]   cnt_rd    [MP];
    logic [31:0]   cnt_wr    [MP];
    logic [31:0]   cnt_stall [MP];
    logic          err_q;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [7:0] port_seed(input int i);
        logic [7:0] s;
        s = SEED ^ 8'(i);
        return (s == 8'd0) ? 8'h01 : s;
    endfunction

    always_comb begin
        in_range = '0;
        stall    = '0;
        active   = '0;
        lost     = '0;
        gnt      = '0;
        for (int i = 0; i < MP; i++) begin
            addr[i]     = add_i[i*32 +: 32];
            word_idx[i] = (addr[i] - BASE_ADDR) >> OFFS;
            in_range[i] = (addr[i] >= BASE_ADDR) && (word_idx[i] < 32'(MEMORY_SIZE));
            stall[i]    = stallable_i && ({24'd0, lfsr[i]} < 32'(STALL_TH));
            active[i]   = rst_ni && req_i[i] && enable_i && !stall[i];
        end
        // Arbitration happens after stall masking: a stalled port never blocks others.
        for (int i = 0; i < MP; i++) begin
            for (int j = 0; j < i; j++) begin
                if (active[j] && (word_idx[j] == word_idx[i])) lost[i] = 1'b1;
            end
        end
        for (int i = 0; i < MP; i++) begin
            gnt[i]     = active[i] && !lost[i];
            rd_word[i] = in_range[i] ? mem[word_idx[i][AW-1:0]] : '0;
            for (int b = 0; b < BW; b++) begin
                merged[i][8*b +: 8] = be_i[i*BW + b] ? data_i[i*DW + 8*b +: 8]
                                                     : rd_word[i][8*b +: 8];
            end
            resp_dat_p0[i] = !in_range[i] ? '0 : (wen_i[i] ? rd_word[i] : merged[i]);
        end
        oor_gnt = gnt & ~in_range;
    end

    // Memory is deliberately outside reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MP; i++) begin
            if (gnt[i] && !wen_i[i] && in_range[i]) mem[word_idx[i][AW-1:0]] <= merged[i];
        end
    end

    // ---- response pipeline: stage 0 captures the grant, last stage drives outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < LATENCY; s++) vld_pipe[s] <= '0;
        end else begin
            vld_pipe[0] <= gnt;
            for (int s = 1; s < LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MP; i++) begin
            dat_pipe[0][i] <= resp_dat_p0[i];
            for (int s = 1; s < LATENCY; s++) dat_pipe[s][i] <= dat_pipe[s-1][i];
        end
    end

    // ---- control state: LFSRs, counters, sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MP; i++) begin
                lfsr[i]      <= port_seed(i);
                cnt_rd[i]    <= '0;
                cnt_wr[i]    <= '0;
                cnt_stall[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < MP; i++) begin
                lfsr[i] <= lfsr_next(lfsr[i]);
                if (clear_i) begin
                    cnt_rd[i]    <= '0;
                    cnt_wr[i]    <= '0;
                    cnt_stall[i] <= '0;
                end else begin
                    if (gnt[i] && wen_i[i])  cnt_rd[i] <= cnt_rd[i] + 32'd1;
                    if (gnt[i] && !wen_i[i]) cnt_wr[i] <= cnt_wr[i] + 32'd1;
                    if (req_i[i] && enable_i && !gnt[i]) cnt_stall[i] <= cnt_stall[i] + 32'd1;
                end
            end
            err_q <= clear_i ? 1'b0 : (err_q | (|oor_gnt));
        end
    end

    always_comb begin
        gnt_o       = gnt;
        r_valid_o   = vld_pipe[LATENCY-1];
        err_o       = err_q;
        r_data_o    = '0;
        cnt_rd_o    = '0;
        cnt_wr_o    = '0;
        cnt_stall_o = '0;
        for (int i = 0; i < MP; i++) begin
            r_data_o[i*DW +: DW]  = vld_pipe[LATENCY-1][i] ? dat_pipe[LATENCY-1][i] : '0;
            cnt_rd_o[i*32 +: 32]    = cnt_rd[i];
            cnt_wr_o[i*32 +: 32]    = cnt_wr[i];
            cnt_stall_o[i*32 +: 32] = cnt_stall[i];
        end
    end

endmodule

// File: tb/tb_tb_tcdm_memory_model.sv
// Bench for tb_tcdm_memory_model: a 2-port LATENCY=1 instance with stall injection
// and a 1-port LATENCY=4 instance, checked against a reference memory and scoreboard.
module tb_tb_tcdm_memory_model;

    localparam logic [31:0] BASE_A = 32'h1000;
    localparam int          MEM_A  = 256;
    localparam int          MEM_B  = 64;
    localparam int          LAT_A  = 1;
    localparam int          LAT_B  = 4;
    localparam logic [7:0]  SEED   = 8'hA5;

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en_a, stl_a, clr;
    logic [1:0]  req_a, wen_a;
    logic [31:0] add_a [2];
    logic [31:0] dat_a [2];
    logic [3:0]  be_a  [2];
    logic [1:0]  gnt_a, rv_a;
    logic [63:0] rd_a, cr_a, cw_a, cs_a;
    logic        err_a;

    logic        en_b, req_b, wen_b;
    logic [31:0] add_b, dat_b;
    logic [3:0]  be_b;
    logic        gnt_b, rv_b, err_b;
    logic [31:0] rd_b, cr_b, cw_b, cs_b;

    logic [31:0] ref_a [MEM_A];
    logic [31:0] ref_b [MEM_B];
    logic [31:0] m_rd [3];
    logic [31:0] m_wr [3];
    logic [31:0] m_st [3];
    logic        m_err_a, m_err_b;
    logic [7:0]  mlfsr [2];
    exp_t        sbq [3][$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    tb_tcdm_memory_model #(
        .MP(2), .DW(32), .MEMORY_SIZE(MEM_A), .BASE_ADDR(BASE_A),
        .LATENCY(LAT_A), .STALL_TH(128), .SEED(SEED)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_a), .stallable_i(stl_a), .clear_i(clr),
        .req_i(req_a), .add_i({add_a[1], add_a[0]}), .wen_i(wen_a),
        .be_i({be_a[1], be_a[0]}), .data_i({dat_a[1], dat_a[0]}),
        .gnt_o(gnt_a), .r_data_o(rd_a), .r_valid_o(rv_a), .err_o(err_a),
        .cnt_rd_o(cr_a), .cnt_wr_o(cw_a), .cnt_stall_o(cs_a)
    );

    tb_tcdm_memory_model #(
        .MP(1), .DW(32), .MEMORY_SIZE(MEM_B), .BASE_ADDR(32'h0),
        .LATENCY(LAT_B), .STALL_TH(0), .SEED(SEED)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_b), .stallable_i(1'b1), .clear_i(clr),
        .req_i(req_b), .add_i(add_b), .wen_i(wen_b), .be_i(be_b), .data_i(dat_b),
        .gnt_o(gnt_b), .r_data_o(rd_b), .r_valid_o(rv_b), .err_o(err_b),
        .cnt_rd_o(cr_b), .cnt_wr_o(cw_b), .cnt_stall_o(cs_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // Response monitor: each valid pulse must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                logic        v;
                logic [31:0] d;
                exp_t        e;
                v = (k == 2) ? rv_b : rv_a[k];
                d = (k == 2) ? rd_b : rd_a[k*32 +: 32];
                if (v) begin
                    checks++;
                    if (sbq[k].size() == 0) begin
                        errors++;
                        $display("FAIL resp%0d unexpected cyc=%0d data=%h", k, cyc, d);
                    end else begin
                        e = sbq[k].pop_front();
                        if (e.due != cyc || d !== e.d) begin
                            errors++;
                            $display("FAIL resp%0d cyc=%0d data=%h required cyc=%0d data=%h",
                                     k, cyc, d, e.due, e.d);
                        end
                    end
                end else begin
                    checks++;
                    if (d !== 32'd0) begin
                        errors++;
                        $display("FAIL rdata_idle%0d got=%h required=0", k, d);
                    end
                    if (sbq[k].size() != 0) begin
                        checks++;
                        if (sbq[k][0].due <= cyc) begin
                            errors++;
                            $display("FAIL resp%0d missing cyc=%0d required data=%h", k, cyc,
                                     sbq[k][0].d);
                            void'(sbq[k].pop_front());
                        end
                    end
                end
            end
        end
    end

    // One clock cycle: predict grants, push expected responses, update the model, then compare state.
    task automatic tick();
        logic [1:0]  act, eg;
        logic [31:0] widx [2];
        logic [31:0] d, wb, r, w, s;
        logic        inr, oor_a, oor_b, actb;
        exp_t        e;
        #1;
        for (int p = 0; p < 2; p++) begin
            widx[p] = (add_a[p] - BASE_A) >> 2;
            act[p]  = req_a[p] && en_a && !(stl_a && (mlfsr[p] < 8'd128));
        end
        eg[0] = act[0];
        eg[1] = act[1] && !(act[0] && (widx[0] == widx[1]));
        checks++;
        if (gnt_a !== eg) begin
            errors++;
            $display("FAIL gnt_a cyc=%0d got=%b required=%b", cyc, gnt_a, eg);
        end
        oor_a = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (req_a[p] && en_a && !eg[p]) m_st[p]++;
            if (eg[p]) begin
                inr = (add_a[p] >= BASE_A) && (widx[p] < 32'(MEM_A));
                d   = 32'd0;
                if (wen_a[p]) begin
                    m_rd[p]++;
                    if (inr) d = ref_a[widx[p][7:0]];
                end else begin
                    m_wr[p]++;
                    if (inr) begin
                        d = merge(ref_a[widx[p][7:0]], dat_a[p], be_a[p]);
                        ref_a[widx[p][7:0]] = d;
                    end
                end
                if (!inr) oor_a = 1'b1;
                e.due = cyc + LAT_A;
                e.d   = d;
                sbq[p].push_back(e);
            end
        end
        actb = req_b && en_b;
        checks++;
        if (gnt_b !== actb) begin
            errors++;
            $display("FAIL gnt_b cyc=%0d got=%b required=%b", cyc, gnt_b, actb);
        end
        oor_b = 1'b0;
        if (actb) begin
            wb  = add_b >> 2;
            inr = wb < 32'(MEM_B);
            d   = 32'd0;
            if (wen_b) begin
                m_rd[2]++;
                if (inr) d = ref_b[wb[5:0]];
            end else begin
                m_wr[2]++;
                if (inr) begin
                    d = merge(ref_b[wb[5:0]], dat_b, be_b);
                    ref_b[wb[5:0]] = d;
                end
            end
            if (!inr) oor_b = 1'b1;
            e.due = cyc + LAT_B;
            e.d   = d;
            sbq[2].push_back(e);
        end
        if (clr) begin
            for (int k = 0; k < 3; k++) begin
                m_rd[k] = 0; m_wr[k] = 0; m_st[k] = 0;
            end
            m_err_a = 1'b0;
            m_err_b = 1'b0;
        end else begin
            m_err_a = m_err_a | oor_a;
            m_err_b = m_err_b | oor_b;
        end
        for (int p = 0; p < 2; p++) mlfsr[p] = lfsr_next(mlfsr[p]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            r = (k == 2) ? cr_b : cr_a[k*32 +: 32];
            w = (k == 2) ? cw_b : cw_a[k*32 +: 32];
            s = (k == 2) ? cs_b : cs_a[k*32 +: 32];
            checks++;
            if ({r, w, s} !== {m_rd[k], m_wr[k], m_st[k]}) begin
                errors++;
                $display("FAIL cnt%0d cyc=%0d got rd=%0d wr=%0d st=%0d required rd=%0d wr=%0d st=%0d",
                         k, cyc, r, w, s, m_rd[k], m_wr[k], m_st[k]);
            end
        end
        checks++;
        if ({err_a, err_b} !== {m_err_a, m_err_b}) begin
            errors++;
            $display("FAIL err cyc=%0d got=%b%b required=%b%b", cyc, err_a, err_b, m_err_a, m_err_b);
        end
    endtask

    task automatic idle(input int n);
        req_a = 2'b00;
        req_b = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_a(input int p, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        wen_a[p] = rd;
        add_a[p] = a;
        dat_a[p] = d;
        be_a[p]  = be;
    endtask

    task automatic set_b(input logic rd, input logic [31:0] a, input logic [31:0] d);
        wen_b = rd;
        add_b = a;
        dat_b = d;
        be_b  = 4'hF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 2'b11;
        req_b = 1'b1;
        en_a  = 1'b1;
        en_b  = 1'b1;
        clr   = 1'b0;
        #1;
        checks++;
        if ({gnt_a, gnt_b} !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt got=%b%b required=000", gnt_a, gnt_b);
        end
        for (int k = 0; k < 3; k++) begin
            sbq[k].delete();
            m_rd[k] = 0; m_wr[k] = 0; m_st[k] = 0;
        end
        m_err_a  = 1'b0;
        m_err_b  = 1'b0;
        mlfsr[0] = SEED;
        mlfsr[1] = SEED ^ 8'h01;
        @(posedge clk);
        #1;
        checks++;
        if ({rv_a, rv_b, rd_a, rd_b, err_a, err_b} !== '0) begin
            errors++;
            $display("FAIL reset_out got rv=%b%b rd=%h/%h err=%b%b required all 0",
                     rv_a, rv_b, rd_a, rd_b, err_a, err_b);
        end
        checks++;
        if ({cr_a, cw_a, cs_a, cr_b, cw_b, cs_b} !== '0) begin
            errors++;
            $display("FAIL reset_cnt got rd=%h wr=%h st=%h b=%h/%h/%h required 0",
                     cr_a, cw_a, cs_a, cr_b, cw_b, cs_b);
        end
        @(posedge clk);
        #1;
        req_a = 2'b00;
        req_b = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        set_a(0, 1'b0, BASE_A, 32'hDEADBEEF, 4'hF);
        req_a = 2'b01;
        tick();
        set_a(0, 1'b1, BASE_A, 32'h0, 4'hF);
        tick();
        idle(2);
        checks++;
        if (cw_a[31:0] !== 32'd1 || cr_a[31:0] !== 32'd1) begin
            errors++;
            $display("FAIL wr_rd_cnt got wr=%0d rd=%0d required wr=1 rd=1", cw_a[31:0], cr_a[31:0]);
        end
    endtask

    task automatic test_partial();
        set_a(1, 1'b0, BASE_A + 32'h0C, 32'h11223344, 4'hF);
        req_a = 2'b10;
        tick();
        set_a(1, 1'b0, BASE_A + 32'h0C, 32'h0000AA00, 4'b0010);
        tick();
        set_a(1, 1'b1, BASE_A + 32'h0C, 32'h0, 4'hF);
        tick();
        idle(2);
    endtask

    task automatic test_conflict();
        set_a(0, 1'b0, BASE_A + 32'h14, 32'hCAFE0005, 4'hF);
        req_a = 2'b01;
        tick();
        set_a(0, 1'b1, BASE_A + 32'h14, 32'h0, 4'hF);
        set_a(1, 1'b1, BASE_A + 32'h14, 32'h0, 4'hF);
        req_a = 2'b11;
        #1;
        checks++;
        if (gnt_a !== 2'b01) begin
            errors++;
            $display("FAIL conflict_gnt got=%b required=01", gnt_a);
        end
        tick();
        req_a = 2'b10;
        #1;
        checks++;
        if (gnt_a !== 2'b10) begin
            errors++;
            $display("FAIL conflict_retry got=%b required=10", gnt_a);
        end
        tick();
        checks++;
        if (cs_a[63:32] !== 32'd1) begin
            errors++;
            $display("FAIL conflict_stall got=%0d required=1", cs_a[63:32]);
        end
        set_a(0, 1'b0, BASE_A + 32'h14, 32'h5555AAAA, 4'hF);
        req_a = 2'b11;
        tick();
        req_a = 2'b10;
        tick();
        set_a(0, 1'b0, BASE_A + 32'h18, 32'h01020304, 4'hF);
        req_a = 2'b11;
        tick();
        idle(2);
    endtask

    task automatic test_oor();
        set_a(0, 1'b1, BASE_A + 32'(4 * MEM_A), 32'h0, 4'hF);
        set_a(1, 1'b0, BASE_A - 32'h4, 32'hBADBAD00, 4'hF);
        req_a = 2'b11;
        tick();
        checks++;
        if (err_a !== 1'b1) begin
            errors++;
            $display("FAIL oor_err got=%b required=1", err_a);
        end
        set_a(1, 1'b0, BASE_A + 32'(4 * MEM_A), 32'hBADBAD11, 4'hF);
        req_a = 2'b10;
        tick();
        set_a(0, 1'b1, BASE_A, 32'h0, 4'hF);
        req_a = 2'b01;
        tick();
        idle(3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL oor_clear got=%b required=0", err_a);
        end
        idle(1);
    endtask

    task automatic test_clear_override();
        set_a(0, 1'b0, BASE_A + 32'h24, 32'h99887766, 4'hF);
        req_a = 2'b01;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (cw_a[31:0] !== 32'd0) begin
            errors++;
            $display("FAIL clear_override got=%0d required=0", cw_a[31:0]);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        req_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_b(1'b0, 32'(4 * i), 32'hA0000000 + 32'(i * 17));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_b(1'b1, 32'(4 * i), 32'h0);
            tick();
        end
        idle(6);
    endtask

    task automatic test_enable();
        set_b(1'b1, 32'h4, 32'h0);
        req_b = 1'b1;
        tick();
        en_b = 1'b0;
        en_a = 1'b0;
        set_a(0, 1'b1, BASE_A, 32'h0, 4'hF);
        req_a = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        en_b = 1'b1;
        en_a = 1'b1;
        idle(2);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 16; i++) begin
            set_a(0, 1'b0, BASE_A + 32'(4 * (16 + i)), $urandom, 4'hF);
            set_a(1, 1'b0, BASE_A + 32'(4 * (32 + i)), $urandom, 4'hF);
            req_a = 2'b11;
            tick();
        end
        clr = 1'b1;
        idle(1);
        clr   = 1'b0;
        stl_a = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            set_a(0, 1'b0, BASE_A + 32'(4 * (16 + i % 16)), $urandom, 4'hF);
            set_a(1, 1'b0, BASE_A + 32'(4 * (32 + i % 16)), $urandom, 4'hF);
            req_a = 2'b11;
            tick();
        end
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (cs_a[p*32 +: 32] < 32'd400 || cs_a[p*32 +: 32] > 32'd600) begin
                errors++;
                $display("FAIL stall_rate%0d got=%0d required 400..600", p, cs_a[p*32 +: 32]);
            end
        end
        for (int i = 0; i < 7; i++) tick();
        test_reset();
        stl_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_a(0, 1'b1, BASE_A + 32'(4 * (16 + i)), 32'h0, 4'hF);
            set_a(1, 1'b1, BASE_A + 32'(4 * (32 + i)), 32'h0, 4'hF);
            req_a = 2'b11;
            tick();
        end
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        stl_a = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        clr   = 1'b0;
        req_a = 2'b00;
        req_b = 1'b0;
        wen_a = 2'b11;
        for (int p = 0; p < 2; p++) begin
            add_a[p] = BASE_A;
            dat_a[p] = 32'h0;
            be_a[p]  = 4'hF;
        end
        set_b(1'b1, 32'h0, 32'h0);
        test_reset();
        test_write_read();
        test_partial();
        test_conflict();
        test_oor();
        test_clear_override();
        test_back_to_back();
        test_enable();
        test_stall();
        idle(6);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sbq[k].size() != 0) begin
                errors++;
                $display("FAIL drain%0d pending=%0d required=0", k, sbq[k].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tb_tcdm_memory_model.md
TB_TCDM_MEMORY_MODEL -- requirements
Module: tb_tcdm_memory_model

Interface
REQ-001 SHALL have parameter MP, default 2: number of TCDM slave ports, range 1..16.
REQ-002 SHALL have parameter DW, default 32: data width in bits, 32 or 64; BW = DW/8.
REQ-003 SHALL have parameter MEMORY_SIZE, default 1024: depth in DW-bit words, power of two.
REQ-004 SHALL have parameter BASE_ADDR, default 0: byte address of word 0.
REQ-005 SHALL have parameter LATENCY, default 1: cycles from grant to r_valid, range 1..8.
REQ-006 SHALL have parameter STALL_TH, default 0: grant withheld when port LFSR[7:0] < STALL_TH, range 0..255.
REQ-007 SHALL have parameter SEED, default 8'hA5: nonzero base LFSR seed; port i seed = SEED ^ i, forced nonzero.
REQ-008 clk_i  in  1  sole clock; all state on rising edge.
REQ-009 rst_ni  in  1  asynchronous active-low reset.
REQ-010 enable_i  in  1  when 0, no grants, no state change except pipeline drain.
REQ-011 stallable_i  in  1  when 1, LFSR stall injection active.
REQ-012 clear_i  in  1  synchronous clear of counters and err_o.
REQ-013 req_i  in  MP  per-port request.
REQ-014 add_i  in  MP*32  per-port byte address.
REQ-015 wen_i  in  MP  1 = read, 0 = write.
REQ-016 be_i  in  MP*BW  byte enables.
REQ-017 data_i  in  MP*DW  write data.
REQ-018 gnt_o  out  MP  grant, combinational.
REQ-019 r_data_o  out  MP*DW  response data.
REQ-020 r_valid_o  out  MP  response valid, one pulse per grant.
REQ-021 err_o  out  1  sticky out-of-range flag.
REQ-022 cnt_rd_o, cnt_wr_o, cnt_stall_o  out  MP*32 each  per-port granted reads, granted writes, stalled request cycles.

Function
REQ-023 Word index = (add_i - BASE_ADDR) >> log2(BW); address in range iff BASE_ADDR <= add_i and index < MEMORY_SIZE.
REQ-024 gnt_o[i] = req_i[i] & enable_i & ~stall[i] & ~lost[i].
REQ-025 stall[i] = stallable_i & (lfsr[i][7:0] < STALL_TH); STALL_TH = 0 never stalls.
REQ-026 Each port: 8-bit Fibonacci LFSR, taps 8,6,5,4, advances every cycle after reset, independent of req_i.
REQ-027 Conflict: ports (after stall masking) addressing same word in same cycle -> only lowest index granted; lost[i] = 1 for others.
REQ-028 Granted write: memory byte j updated with data_i byte j where be_i[j] = 1, else unchanged; visible to reads granted in later cycles.
REQ-029 Granted read: returns memory word as before any write in the same cycle.
REQ-030 Write response: r_valid pulses after LATENCY cycles, r_data = post-write merged word.
REQ-031 Response pipeline: per-port LATENCY-stage shift register of {valid, data}; fully pipelined, one grant per port per cycle, order preserved.
REQ-032 r_data_o SHALL be 0 when r_valid_o = 0.
REQ-033 Out-of-range granted access: still granted and responded; read data 0, write discarded; err_o set next cycle, held until clear_i or reset.
REQ-034 Counters: 32-bit, wrap to 0 past 2^32-1; cnt_stall increments on req_i & enable_i & ~gnt_o (stall or conflict).
REQ-035 clear_i zeroes counters and err_o next edge, overriding same-cycle increments; pipeline and memory unaffected.
REQ-036 enable_i = 0: in-flight responses still delivered at their scheduled cycle.

Reset
REQ-037 rst_ni low: gnt_o 0 (combinational), r_valid_o 0, r_data_o 0, err_o 0, all counters 0, pipeline empty, LFSRs to seeds; asynchronous assert, deassert synchronous to clk_i.
REQ-038 Memory contents SHALL NOT be altered by reset; reset mid-transaction drops in-flight responses without memory corruption of already granted writes.

Verification
REQ-039 MP=1, DW=32, LATENCY=1: write 0xDEADBEEF to 0x0, be=0xF; read 0x0 -> r_valid 1 cycle after grant, r_data 0xDEADBEEF, cnt_wr=1, cnt_rd=1.
REQ-040 Partial write be=4'b0010, data 0x0000AA00 over 0x11223344 -> readback 0x1122AA44.
REQ-041 MP=2, both read word 5 same cycle -> gnt_o=2'b01, port 1 granted next cycle, cnt_stall[1]=1.
REQ-042 LATENCY=4, back-to-back reads addresses 0,4,8 -> three r_valid pulses cycles 4,5,6 after first grant, in order.
REQ-043 Read add_i = BASE_ADDR + 4*MEMORY_SIZE -> granted, r_data 0, err_o=1 until clear_i pulse.
REQ-044 STALL_TH=128, stallable_i=1, 1000 continuous requests -> cnt_stall within 400..600, every grant matched by one r_valid; rst_ni pulse mid-stream -> outputs 0 next cycle.
